// File: rtl/game_pkg.sv
// Shared definitions for the brick-smash game flow: state encoding used by the
// sequencer, the play mechanism and the banner renderer.
package game_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    LOST      = 3'd4,
    LVLUP     = 3'd5,
    GAME_OVER = 3'd6,
    WIN       = 3'd7
  } game_state_t;

  // Largest of three frame counts; sizes the shared frame timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/game_sequencer_frame_timer.sv
// Frame counter for the timed game states (serve hold, ball-lost and level-up
// banners). Counts frame ticks since the last clear and flags the target-th one.
module frame_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               frame_tick,
  input  logic [TIMER_W-1:0] target,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  // Tick counter; a tick arriving in the clear cycle is dropped, not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (frame_tick) begin
      count <= count + 1'b1;
    end
  end

  // The target-th tick after the clear cycle completes the interval.
  assign done = frame_tick & ~clear & (count == target - 1'b1);

endmodule

// File: rtl/game_sequencer.sv
// Top-level game-flow sequencer for brick-smash: serves the ball, gates ball and
// paddle motion, and keeps lives, score and level. All outputs are registered.
module game_sequencer
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int SCORE_W      = 10,
  parameter int BRICK_POINTS = 1,
  parameter int MAX_LEVEL    = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int LOST_FRAMES  = 90,
  parameter int LVL_FRAMES   = 120
) (
  input  logic               clk_100MHz,
  input  logic               reset_n,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               brick_hit,
  input  logic               ball_lost,
  input  logic               bricks_clear,
  output logic [2:0]         state,
  output logic               ball_en,
  output logic               paddle_en,
  output logic               serve,
  output logic               wall_reload,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         level
);

  localparam int MAX_FRAMES = max3(SERVE_FRAMES, LOST_FRAMES, LVL_FRAMES);
  localparam int TIMER_W    = $clog2(MAX_FRAMES + 1);

  game_state_t        fsm_state;
  game_state_t        fsm_next;
  logic               start_q;
  logic               start_rise;
  logic               entry;
  logic               timer_done;
  logic [TIMER_W-1:0] timer_target;
  logic [2:0]         lives_next;
  logic [SCORE_W-1:0] score_next;
  logic [2:0]         level_next;
  logic               serve_next;
  logic               reload_next;

  // Adds one brick's worth of points, pinning at the top of the score range.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + (SCORE_W+1)'(BRICK_POINTS);
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

  assign start_rise = start & ~start_q;
  assign state      = fsm_state;

  // Interval length for whichever timed state is active.
  always_comb begin
    timer_target = TIMER_W'(SERVE_FRAMES);
    case (fsm_state)
      LOST:    timer_target = TIMER_W'(LOST_FRAMES);
      LVLUP:   timer_target = TIMER_W'(LVL_FRAMES);
      default: timer_target = TIMER_W'(SERVE_FRAMES);
    endcase
  end

  // The timer is held clear during the first cycle of every new state.
  frame_timer #(.TIMER_W(TIMER_W)) u_frame_timer (
    .clk        (clk_100MHz),
    .rst_n      (reset_n),
    .clear      (entry),
    .frame_tick (frame_tick),
    .target     (timer_target),
    .done       (timer_done)
  );

  // State register, start edge detector and new-state marker.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      fsm_state <= IDLE;
      start_q   <= 1'b0;
      entry     <= 1'b0;
    end else begin
      fsm_state <= fsm_next;
      start_q   <= start;
      entry     <= (fsm_next != fsm_state);
    end
  end

  // Next state plus next values of lives, score, level and the one-cycle pulses.
  always_comb begin
    fsm_next    = fsm_state;
    lives_next  = lives;
    score_next  = score;
    level_next  = level;
    serve_next  = 1'b0;
    reload_next = 1'b0;
    case (fsm_state)
      IDLE: begin
        if (start_rise) begin
          fsm_next    = SERVE;
          lives_next  = 3'(LIVES_INIT);
          score_next  = '0;
          level_next  = 3'd1;
          serve_next  = 1'b1;
          reload_next = 1'b1;
        end
      end
      SERVE: begin
        if (timer_done) fsm_next = PLAY;
      end
      PLAY: begin
        // A brick hit counts even when the same cycle also leaves PLAY.
        if (brick_hit) score_next = sat_add(score);
        if (bricks_clear) begin
          if (level == 3'(MAX_LEVEL)) begin
            fsm_next = WIN;
          end else begin
            fsm_next   = LVLUP;
            level_next = level + 3'd1;
          end
        end else if (ball_lost) begin
          fsm_next   = LOST;
          lives_next = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
        end else if (start_rise) begin
          fsm_next = PAUSE;
        end
      end
      PAUSE: begin
        if (start_rise) fsm_next = PLAY;
      end
      LOST: begin
        if (timer_done) begin
          if (lives == 3'd0) begin
            fsm_next = GAME_OVER;
          end else begin
            fsm_next   = SERVE;
            serve_next = 1'b1;
          end
        end
      end
      LVLUP: begin
        if (timer_done) begin
          fsm_next    = SERVE;
          serve_next  = 1'b1;
          reload_next = 1'b1;
        end
      end
      GAME_OVER, WIN: begin
        if (start_rise) fsm_next = IDLE;
      end
    endcase
  end

  // Registered outputs; enables follow the state being entered.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      lives       <= 3'd0;
      score       <= '0;
      level       <= 3'd0;
      serve       <= 1'b0;
      wall_reload <= 1'b0;
      ball_en     <= 1'b0;
      paddle_en   <= 1'b0;
    end else begin
      lives       <= lives_next;
      score       <= score_next;
      level       <= level_next;
      serve       <= serve_next;
      wall_reload <= reload_next;
      ball_en     <= (fsm_next == PLAY);
      paddle_en   <= (fsm_next == PLAY) || (fsm_next == SERVE);
    end
  end

endmodule
